// File: rtl/sw_pkg.sv
// Shared widths, defaults and helpers for the switch debounce block.
package sw_pkg;

   localparam int SW_WIDTH              = 32;
   localparam int SW_DEB_CYCLES_DEFAULT = 16;

   typedef logic [SW_WIDTH-1:0] sw_vec_t;

   // Counter width able to hold values 0..n without wrapping.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sw_debounce_cell.sv
// One-bit debouncer: disagreement counter, stable level flop and rise/fall pulses.
module sw_debounce_cell
   import sw_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = SW_DEB_CYCLES_DEFAULT
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic sw,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam int CW = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt;

   // Any cycle of agreement throws away the partial count, so short glitches never land.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt    <= '0;
         stable <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (sw == stable) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt    <= '0;
            stable <= sw;
            rise   <= sw;
            fall   <= ~sw;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sw_debounce.sv
// Per-bit switch debouncer with edge pulses, sticky change flags and optional IRQ.
// Define SW_DEBOUNCE_IRQ_EN to build the level interrupt; otherwise o_irq is tied low.
module sw_debounce
   import sw_pkg::*;
#(
   parameter int WIDTH           = SW_WIDTH,
   parameter int DEBOUNCE_CYCLES = SW_DEB_CYCLES_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_sw,
   input  logic             i_clr_en,
   input  logic [WIDTH-1:0] i_clr_mask,
   input  logic [WIDTH-1:0] i_irq_mask,
   output logic [WIDTH-1:0] o_sw_stable,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall,
   output logic [WIDTH-1:0] o_chg_sticky,
   output logic             o_irq
);

   logic [WIDTH-1:0] sticky_next;

   for (genvar b = 0; b < WIDTH; b++) begin : g_cell
      sw_debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .i_clk  (i_clk),
         .i_reset(i_reset),
         .sw     (i_sw[b]),
         .stable (o_sw_stable[b]),
         .rise   (o_rise[b]),
         .fall   (o_fall[b])
      );
   end

   // A pulse arriving alongside a clear must survive, so the set term is ORed in last.
   always_comb begin
      sticky_next = (o_chg_sticky & ~({WIDTH{i_clr_en}} & i_clr_mask)) | o_rise | o_fall;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_chg_sticky <= '0;
      end else begin
         o_chg_sticky <= sticky_next;
      end
   end

`ifdef SW_DEBOUNCE_IRQ_EN
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_irq <= 1'b0;
      end else begin
         o_irq <= |(sticky_next & i_irq_mask);
      end
   end
`else
   logic irq_mask_unused;
   assign irq_mask_unused = ^i_irq_mask;
   assign o_irq           = 1'b0;
`endif

endmodule
